// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Default sizes live here so the top, sub-module and interface agree.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;
    localparam int DEF_NUM_WR = 2;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write ports, read ports, issue/flush scoreboard control.
// The register file is the slave; whoever drives reads/writes is the master.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR
) ();

    localparam int NREG = 2 ** ADDR_W;

    logic [NUM_WR-1:0]        i_wr_en;
    logic [NUM_WR*ADDR_W-1:0] i_wr_addr;
    logic [NUM_WR*DATA_W-1:0] i_wr_data;
    logic [NUM_RD*ADDR_W-1:0] i_rd_addr;
    logic [NUM_RD*DATA_W-1:0] o_rd_data;
    logic                     i_iss_en;
    logic [ADDR_W-1:0]        i_iss_addr;
    logic                     i_flush;
    logic [NUM_RD-1:0]        o_rd_busy;
    logic [NREG-1:0]          o_busy_vec;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
        output i_iss_en, i_iss_addr, i_flush,
        input  o_rd_data, o_rd_busy, o_busy_vec
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr,
        input  i_iss_en, i_iss_addr, i_flush,
        output o_rd_data, o_rd_busy, o_busy_vec
    );

endinterface

// File: rtl/regfile_wr_sel.sv
// Per-register write resolution: which registers are written this cycle and with what data.
// Register 0 is never hit; among ports hitting one register, the highest index wins.
module regfile_wr_sel
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_WR = DEF_NUM_WR,
    localparam int NREG  = 2 ** ADDR_W
) (
    input  logic [NUM_WR-1:0]             i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]      i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]      i_wr_data,
    output logic [NREG-1:0]               o_hit,
    output logic [NREG-1:0][DATA_W-1:0]   o_data
);

    // Ascending port scan so later (higher-index) matches overwrite earlier ones.
    always_comb begin
        o_hit  = '0;
        o_data = '0;
        for (int a = 1; a < NREG; a++) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (i_wr_en[k] && (i_wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(a))) begin
                    o_hit[a]  = 1'b1;
                    o_data[a] = i_wr_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and a pending-write
// scoreboard (issue sets, write clears, flush clears all).
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int BYPASS = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    regfile_mp_if.slave   bus
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] r_regs;
    logic [NREG-1:0]             r_pend;
    logic [NREG-1:0]             w_hit;
    logic [NREG-1:0][DATA_W-1:0] w_sel_data;

    regfile_wr_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_wr_sel (
        .i_wr_en   (bus.i_wr_en),
        .i_wr_addr (bus.i_wr_addr),
        .i_wr_data (bus.i_wr_data),
        .o_hit     (w_hit),
        .o_data    (w_sel_data)
    );

    // w_hit[0] is never set, so register 0 stays at its reset value of zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_regs <= '0;
        end else begin
            for (int a = 0; a < NREG; a++) begin
                if (w_hit[a]) begin
                    r_regs[a] <= w_sel_data[a];
                end
            end
        end
    end

    // Issue takes priority over a completing write: the issue names a newer producer.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            r_pend <= '0;
        end else begin
            for (int a = 1; a < NREG; a++) begin
                if (bus.i_iss_en && (bus.i_iss_addr == ADDR_W'(a))) begin
                    r_pend[a] <= 1'b1;
                end else if (w_hit[a]) begin
                    r_pend[a] <= 1'b0;
                end
            end
        end
    end

    assign bus.o_busy_vec = r_pend;

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = bus.i_rd_addr[j*ADDR_W +: ADDR_W];

        // A forwarded write satisfies the pending producer, so busy drops with it.
        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = r_pend[w_addr];
            if ((BYPASS != 0) && w_hit[w_addr]) begin
                w_data = w_sel_data[w_addr];
                w_busy = 1'b0;
            end
        end

        assign bus.o_rd_data[j*DATA_W +: DATA_W] = w_data;
        assign bus.o_rd_busy[j]                  = w_busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus a randomized model run,
// with expected values queued on a scoreboard as stimulus is applied.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NW   = 2;
    localparam int NREG = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    regfile_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .NUM_WR (NW),
        .BYPASS (1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef enum int {K_DATA, K_BUSY, K_BVEC} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   passCount  = 0;
    int   checkCount = 0;

    function automatic logic [31:0] observe(kind_e k, int p);
        case (k)
            K_DATA:  return bus.o_rd_data[p*DW +: DW];
            K_BUSY:  return {31'b0, bus.o_rd_busy[p]};
            default: return bus.o_busy_vec;
        endcase
    endfunction

    task automatic push(input string tag, input kind_e k, input int p, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = k;
        e.port = p;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic idle();
        bus.i_wr_en    = '0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;
        bus.i_rd_addr  = '0;
        bus.i_iss_en   = 1'b0;
        bus.i_iss_addr = '0;
        bus.i_flush    = 1'b0;
        rst            = 1'b0;
    endtask

    task automatic set_wr(input int k, input logic en, input int addr, input logic [31:0] d);
        bus.i_wr_en[k]              = en;
        bus.i_wr_addr[k*AW +: AW]   = AW'(addr);
        bus.i_wr_data[k*DW +: DW]   = d;
    endtask

    task automatic set_rd(input int j, input int addr);
        bus.i_rd_addr[j*AW +: AW] = AW'(addr);
    endtask

    task automatic set_iss(input int addr);
        bus.i_iss_en   = 1'b1;
        bus.i_iss_addr = AW'(addr);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        for (int r = 0; r < NREG; r++) begin
            @(negedge clk);
            idle();
            set_rd(0, r);
            set_rd(1, NREG - 1 - r);
            push($sformatf("reset_x%0d_data0", r), K_DATA, 0, 32'h0);
            push($sformatf("reset_x%0d_data1", r), K_DATA, 1, 32'h0);
            push($sformatf("reset_x%0d_busy0", r), K_BUSY, 0, 32'h0);
            if (r == 0) push("reset_busy_vec", K_BVEC, 0, 32'h0);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checkCount++;
                if (obs !== e.val) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val);
                else passCount++;
            end
        end
    endtask

    task automatic test_write_conflict();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            idle();
            case (s)
                0: begin
                    set_wr(0, 1'b1, 5, 32'h1111);
                    set_wr(1, 1'b1, 5, 32'h2222);
                    set_rd(0, 5); set_rd(1, 5);
                    push("wc_same_cycle_p0", K_DATA, 0, 32'h2222);
                    push("wc_same_cycle_p1", K_DATA, 1, 32'h2222);
                end
                1: begin
                    set_rd(0, 5); set_rd(1, 5);
                    push("wc_next_cycle_p0", K_DATA, 0, 32'h2222);
                    push("wc_next_cycle_p1", K_DATA, 1, 32'h2222);
                end
                2: begin
                    set_wr(0, 1'b1, 3, 32'hAAAA);
                    set_wr(1, 1'b0, 3, 32'hDEAD);
                    set_rd(0, 3); set_rd(1, 5);
                    push("wc_disabled_port", K_DATA, 0, 32'hAAAA);
                    push("wc_other_reg", K_DATA, 1, 32'h2222);
                end
                3: begin
                    set_wr(0, 1'b1, 10, 32'h10);
                    set_wr(1, 1'b1, 11, 32'h11);
                    set_rd(0, 3); set_rd(1, 10);
                    push("wc_stored_x3", K_DATA, 0, 32'hAAAA);
                    push("wc_bypass_p0_x10", K_DATA, 1, 32'h10);
                end
                default: begin
                    set_rd(0, 10); set_rd(1, 11);
                    push("wc_dual_x10", K_DATA, 0, 32'h10);
                    push("wc_dual_x11", K_DATA, 1, 32'h11);
                end
            endcase
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checkCount++;
                if (obs !== e.val) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val);
                else passCount++;
            end
        end
    endtask

    task automatic test_x0();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            idle();
            set_rd(0, 0); set_rd(1, 0);
            if (s == 0) begin
                set_wr(0, 1'b1, 0, 32'hFFFF_FFFF);
                set_wr(1, 1'b1, 0, 32'hFFFF_FFFF);
                set_iss(0);
                push("x0_write_same_cycle", K_DATA, 0, 32'h0);
                push("x0_busy_same_cycle", K_BUSY, 0, 32'h0);
            end else begin
                push("x0_after_write", K_DATA, 1, 32'h0);
                push("x0_busy_vec", K_BVEC, 0, 32'h0);
                push("x0_busy_after", K_BUSY, 1, 32'h0);
            end
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checkCount++;
                if (obs !== e.val) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val);
                else passCount++;
            end
        end
    endtask

    task automatic test_pending();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            idle();
            set_rd(0, 7); set_rd(1, 7);
            case (s)
                0: begin
                    set_iss(7);
                    push("pend_before_issue_edge", K_BUSY, 0, 32'h0);
                    push("pend_vec_before", K_BVEC, 0, 32'h0);
                end
                1: begin
                    push("pend_busy_p0", K_BUSY, 0, 32'h1);
                    push("pend_busy_p1", K_BUSY, 1, 32'h1);
                    push("pend_vec_x7", K_BVEC, 0, 32'h0000_0080);
                    push("pend_old_data", K_DATA, 0, 32'h0);
                end
                2: begin
                    set_wr(1, 1'b1, 7, 32'hABCD);
                    push("pend_bypass_busy", K_BUSY, 0, 32'h0);
                    push("pend_bypass_data", K_DATA, 0, 32'hABCD);
                    push("pend_vec_still_set", K_BVEC, 0, 32'h0000_0080);
                end
                default: begin
                    push("pend_cleared_busy", K_BUSY, 1, 32'h0);
                    push("pend_cleared_vec", K_BVEC, 0, 32'h0);
                    push("pend_stored_data", K_DATA, 1, 32'hABCD);
                end
            endcase
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checkCount++;
                if (obs !== e.val) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val);
                else passCount++;
            end
        end
    endtask

    task automatic test_issue_flush();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            idle();
            case (s)
                0: begin
                    set_iss(9);
                    set_wr(0, 1'b1, 9, 32'h99);
                    set_rd(0, 9);
                    push("iw_bypass_x9", K_DATA, 0, 32'h99);
                end
                1: begin
                    bus.i_flush = 1'b1;
                    set_iss(3);
                    set_wr(0, 1'b1, 12, 32'h1212);
                    set_rd(0, 9);
                    push("iw_issue_wins_vec", K_BVEC, 0, 32'h0000_0200);
                    push("iw_issue_wins_busy", K_BUSY, 0, 32'h1);
                    push("iw_stored_x9", K_DATA, 0, 32'h99);
                end
                default: begin
                    set_rd(0, 3); set_rd(1, 12);
                    push("flush_vec_clear", K_BVEC, 0, 32'h0);
                    push("flush_beats_issue", K_BUSY, 0, 32'h0);
                    push("flush_write_lands", K_DATA, 1, 32'h1212);
                end
            endcase
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checkCount++;
                if (obs !== e.val) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val);
                else passCount++;
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] obs;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            idle();
            case (s)
                0: set_wr(0, 1'b1, 4, 32'h55);
                1: begin
                    set_iss(6);
                    set_rd(0, 4);
                    push("rm_x4_before", K_DATA, 0, 32'h55);
                end
                2: begin
                    rst = 1'b1;
                    set_wr(0, 1'b1, 4, 32'h77);
                    set_iss(8);
                    set_rd(1, 6);
                    push("rm_vec_before_reset", K_BVEC, 0, 32'h0000_0040);
                    push("rm_busy_before_reset", K_BUSY, 1, 32'h1);
                end
                3: begin
                    set_rd(0, 4); set_rd(1, 6);
                    push("rm_x4_after_reset", K_DATA, 0, 32'h0);
                    push("rm_busy_after_reset", K_BUSY, 1, 32'h0);
                    push("rm_vec_after_reset", K_BVEC, 0, 32'h0);
                end
                default: begin
                    set_rd(0, 3); set_rd(1, 5);
                    push("rm_x3_cleared", K_DATA, 0, 32'h0);
                    push("rm_x5_cleared", K_DATA, 1, 32'h0);
                end
            endcase
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checkCount++;
                if (obs !== e.val) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val);
                else passCount++;
            end
        end
    endtask

    // Behavioural model of storage and pending bits driven with random traffic on x0..x7.
    task automatic test_random();
        exp_t        e;
        logic [31:0] obs;
        logic [NW-1:0] en;
        reg_addr_t   wa [NW];
        logic [31:0] wd [NW];
        reg_addr_t   ra [NR];
        reg_addr_t   ia;
        logic        iss, fl, b;
        logic [31:0] d;
        logic [31:0] m_reg [NREG];
        logic [NREG-1:0] m_pend;

        @(negedge clk);
        idle();
        rst = 1'b1;
        for (int a = 0; a < NREG; a++) m_reg[a] = 32'h0;
        m_pend = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            idle();
            for (int k = 0; k < NW; k++) begin
                en[k] = 1'($urandom_range(0, 1));
                wa[k] = reg_addr_t'($urandom_range(0, 7));
                wd[k] = $urandom;
                set_wr(k, en[k], int'(wa[k]), wd[k]);
            end
            for (int j = 0; j < NR; j++) begin
                ra[j] = reg_addr_t'($urandom_range(0, 7));
                set_rd(j, int'(ra[j]));
            end
            iss = ($urandom_range(0, 2) == 0);
            ia  = reg_addr_t'($urandom_range(0, 7));
            fl  = ($urandom_range(0, 9) == 0);
            bus.i_iss_en   = iss;
            bus.i_iss_addr = ia;
            bus.i_flush    = fl;
            for (int j = 0; j < NR; j++) begin
                d = m_reg[ra[j]];
                b = m_pend[ra[j]];
                for (int k = 0; k < NW; k++) begin
                    if (en[k] && wa[k] == ra[j] && ra[j] != 0) begin
                        d = wd[k];
                        b = 1'b0;
                    end
                end
                push($sformatf("rand%0d_data%0d", i, j), K_DATA, j, d);
                push($sformatf("rand%0d_busy%0d", i, j), K_BUSY, j, {31'b0, b});
            end
            push($sformatf("rand%0d_vec", i), K_BVEC, 0, m_pend);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                obs = observe(e.kind, e.port);
                checkCount++;
                if (obs !== e.val) $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.tag, obs, e.val);
                else passCount++;
            end
            for (int k = 0; k < NW; k++) begin
                if (en[k] && wa[k] != 0) begin
                    m_reg[wa[k]]  = wd[k];
                    m_pend[wa[k]] = 1'b0;
                end
            end
            if (iss && ia != 0) m_pend[ia] = 1'b1;
            if (fl) m_pend = '0;
        end
    endtask

    initial begin
        test_reset();
        test_write_conflict();
        test_x0();
        test_pending();
        test_issue_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, got %0d checks, required completion", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; register count NREG = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of read ports.
REQ-004 Parameter NUM_WR, default 2: number of write ports.
REQ-005 Parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to the read ports.
REQ-006 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 i_rst  in  1  synchronous, active-high reset, sampled on the rising edge of i_clk.
REQ-008 i_wr_en  in  NUM_WR  per-port write enable.
REQ-009 i_wr_addr  in  NUM_WR*ADDR_W  per-port write address, port k at bits [k*ADDR_W +: ADDR_W].
REQ-010 i_wr_data  in  NUM_WR*DATA_W  per-port write data, packed the same way.
REQ-011 i_rd_addr  in  NUM_RD*ADDR_W  per-port read address.
REQ-012 o_rd_data  out  NUM_RD*DATA_W  per-port read data.
REQ-013 i_iss_en  in  1  issue strobe: marks register i_iss_addr as pending a write.
REQ-014 i_iss_addr  in  ADDR_W  destination register being issued.
REQ-015 i_flush  in  1  clears all pending bits.
REQ-016 o_rd_busy  out  NUM_RD  pending status of each read port's addressed register.
REQ-017 o_busy_vec  out  NREG  raw pending-bit vector, registered.

Function
REQ-018 Writes update storage at the rising edge, one-cycle write latency; reads are combinational, zero-cycle latency.
REQ-019 Register 0 reads 0, ignores writes, and is never pending: o_busy_vec[0] is 0 always.
REQ-020 Multiple write ports to the same address in one cycle: the highest-index enabled port wins, for both storage and bypass.
REQ-021 BYPASS=1: a read whose address matches an enabled write (address non-zero) returns that write's data (per REQ-020) in the same cycle; BYPASS=0: it returns the stored old value.
REQ-022 Pending bit p[a] is set at the edge when i_iss_en=1 and i_iss_addr=a (a non-zero).
REQ-023 Pending bit p[a] is cleared at the edge when any enabled write port targets a.
REQ-024 Issue and write to the same register in one cycle: issue wins, p[a] is 1 after the edge (new producer).
REQ-025 i_flush=1 clears all pending bits at the edge, overriding simultaneous issue; writes in that cycle still update storage.
REQ-026 o_rd_busy[j] = p[addr_j] AND NOT (BYPASS=1 AND an enabled write targets addr_j this cycle); 0 for address 0.
REQ-027 Outputs are pure functions of state and current inputs; no X propagation for any in-range address.

Reset
REQ-028 While i_rst=1 at an edge, all registers are set to 0 and all pending bits to 0; writes, issues and flushes that cycle are ignored.
REQ-029 After reset, o_rd_data is 0 on every port and o_rd_busy and o_busy_vec are all 0.
REQ-030 Reset asserted mid-sequence discards all in-flight pending state; no write landing in the reset cycle survives.

Structure
REQ-031 A shared package regfile_pkg SHALL hold the default DATA_W, ADDR_W, NUM_RD and NUM_WR constants and a reg_addr_t typedef.
REQ-032 A single sub-module, regfile_wr_sel, SHALL resolve the winning write port per address (used for storage, bypass and pending-bit clear); read ports are generated instances of one mux.

Verification
REQ-033 Reset, then read x0..x31 on all ports -> all 0; o_busy_vec=0.
REQ-034 Port0 writes x5=0x1111 and port1 writes x5=0x2222 in one cycle, with port 0 reading x5 -> same cycle 0x2222 (BYPASS=1) or old value 0 (BYPASS=0); next cycle 0x2222.
REQ-035 Write x0=0xFFFF_FFFF together with issue x0 -> x0 reads 0; o_busy_vec[0]=0.
REQ-036 Issue x7; next cycle read x7 -> o_rd_busy=1; write x7=0xABCD while reading x7 -> o_rd_busy=0, data 0xABCD; after the edge p[7]=0.
REQ-037 Issue x9 and write x9 in the same cycle -> p[9]=1 after the edge; then flush together with issue x3 -> o_busy_vec all 0.
REQ-038 Write x4=0x55, issue x6, then assert i_rst for one cycle together with a write x4=0x77 -> x4 reads 0; o_busy_vec=0.
